edge_event_bank: RTL and testbench
==================================

# edge_event_bank

Multi-channel edge-to-enable converter for asynchronous or bouncy level inputs (buttons, external strobes, status pins). Each channel has a configurable synchroniser chain, a debounce filter and a run-time edge-mode select. It produces a one-cycle enable per qualified edge, a filtered level, and a sticky pending bit with per-channel clear. The block sits at the boundary between raw pins and the control/interrupt logic, and replaces single-channel rising-edge converters.

## Interface
Parameters:
- WIDTH, 8, number of independent channels (≥1)
- SYNC_STG, 2, synchroniser flops per channel (≥0; 0 = input already synchronous)
- DB_CYC, 4, consecutive cycles a new level must persist before acceptance (≥1; 1 = no filtering)

Ports:
- clk  in  1  single clock; all state on its rising edge
- rst  in  1  reset, synchronous and active-high
- in  in  WIDTH  raw channel levels
- mode  in  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  in  WIDTH  per-channel pending clear, sampled each cycle
- en  out  WIDTH  one-cycle pulse per qualified edge (registered)
- out  out  WIDTH  filtered, debounced level (registered)
- pend  out  WIDTH  sticky event flags (registered)
- irq  out  1  OR of pend (combinational from pend)
- rdy  out  1  high once priming after reset is complete (registered)

## Operation
- Synchroniser: per channel, chain s[0..SYNC_STG-1] shifts in every cycle. The synchronised value y is s[SYNC_STG-1], or in[i] directly when SYNC_STG=0.
- Priming: after rst, a prime counter runs for SYNC_STG+1 cycles. Every priming cycle: out <= y, filter counter held at 0, en and pend not set. The last priming edge fixes the baseline level, which never produces an event. rdy rises on that same edge.
- Debounce (after priming), counter cnt per channel, width clog2(DB_CYC):
  - y == out: cnt <= 0.
  - y != out and cnt == DB_CYC-1: out <= y, cnt <= 0, transition accepted.
  - Otherwise: cnt <= cnt+1.
  - A difference shorter than DB_CYC consecutive cycles is discarded entirely.
- Qualification: an accepted 0→1 transition is rising, 1→0 is falling. en[i] <= 1 on the accepting edge if mode bit [2i] (rising) or [2i+1] (falling) enables that direction. Otherwise en[i] <= 0. mode is sampled on the accepting edge only.
- out always tracks accepted transitions, whatever the mode. Mode 00 still filters.
- Pending: pend[i] <= 1 on any edge that sets en[i]. Otherwise pend[i] is cleared when clr[i]=1. If set and clear occur together, set wins.
- Channels are fully independent. Simultaneous events on several channels all report in the same cycle.

## Timing
- Reset values: s=0, cnt=0, out=0, en=0, pend=0, rdy=0, irq=0. Prime counter is loaded with SYNC_STG+1.
- Reset asserted mid-operation: all of the above take effect on the next edge. Any in-flight debounce is lost and priming restarts after rst deasserts.
- Priming: with rst low from edge 0, rdy=1 and out=baseline from edge SYNC_STG.
- Latency: in changes before edge k and stays stable. out changes and en pulses on edge k+SYNC_STG+DB_CYC-1, both visible in the following cycle. pend is set on the same edge. irq follows pend combinationally.
- en is high for exactly one cycle per accepted transition.
- Back-to-back transitions are spaced at least DB_CYC cycles apart at the output.
- clr takes effect on the edge where it is sampled. pend=0 is visible in the next cycle.

## Test plan
- **Priming:** WIDTH=4, SYNC_STG=2, DB_CYC=4. Hold in=4'b1010 through rst and release. Required: rdy=1 and out=1010 from edge 2, en=0 and pend=0 throughout.
- **Latency:** mode=all 01. Channel 0 goes 0→1 before edge 10. Required: en[0]=1 only in the cycle after edge 15 (10+2+4-1), out[0]=1 from the same edge, pend[0]=1, irq=1.
- **Glitch rejection:** channel 1 high for 3 cycles, then low (DB_CYC=4). Required: no en, out[1] stays 0, cnt returns to 0. Then high for 4 cycles: en[1] pulses once.
- **Modes:** toggle channels 0–3 (modes 00, 01, 10, 11) 0→1→0, each level held 8 cycles. Required: en pulse counts 0, 1, 1, 2. out follows on all four channels. pend set only on channels 1–3.
- **Pending race:** assert clr[2] on the exact edge that sets en[2]. Required: pend[2] stays 1. clr[2] one cycle later: pend[2]=0 next cycle, irq=0 if no other pending.
- **Mid-operation reset:** assert rst for 1 cycle while channel 0 is at cnt=2. Required: all outputs 0 next cycle, priming restarts, and no en is produced for the interrupted transition.

Source files
------------

// File: rtl/edge_event_bank_if.sv
// edge_event_bank_if: channel bus between the raw-pin side and edge_event_bank
//   in    raw channel levels
//   mode  per-channel edge select, [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr   per-channel pending clear
//   en    one-cycle pulse per qualified edge
//   out   filtered, debounced level
//   pend  sticky event flags
//   irq   OR of pend
//   rdy   priming complete
interface edge_event_bank_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0]   in;
    logic [2*WIDTH-1:0] mode;
    logic [WIDTH-1:0]   clr;
    logic [WIDTH-1:0]   en;
    logic [WIDTH-1:0]   out;
    logic [WIDTH-1:0]   pend;
    logic               irq;
    logic               rdy;
    modport master (output in, mode, clr, input en, out, pend, irq, rdy);
    modport slave (input in, mode, clr, output en, out, pend, irq, rdy);
endinterface

// File: rtl/edge_event_bank.sv
// edge_event_bank: multi-channel synchronise + debounce + edge-select event bank
//   clk  single clock, all state on its rising edge
//   rst  synchronous active-high reset
//   bus  edge_event_bank_if slave: in/mode/clr in, en/out/pend/irq/rdy out
module edge_event_bank #(
    parameter int WIDTH    = 8,
    parameter int SYNC_STG = 2,
    parameter int DB_CYC   = 4
) (
    input logic clk,
    input logic rst,
    edge_event_bank_if.slave bus
);
    localparam int CW = DB_CYC > 1 ? $clog2(DB_CYC) : 1;
    localparam int PW = $clog2(SYNC_STG + 2);
    localparam logic [PW-1:0] PC_INIT = PW'(SYNC_STG + 1);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYC - 1);
    logic [WIDTH-1:0] y, out, en, pend, acc, hit;
    logic [CW-1:0]    cnt [WIDTH];
    logic [PW-1:0]    pc;
    logic             rdy, prime;
    if (SYNC_STG == 0) begin : g_nosync
        assign y = bus.in;
    end else begin : g_sync
        logic [WIDTH-1:0] s [SYNC_STG];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < SYNC_STG; j++) s[j] <= '0;
            end else begin
                s[0] <= bus.in;
                for (int j = 1; j < SYNC_STG; j++) s[j] <= s[j-1];
            end
        end
        assign y = s[SYNC_STG-1];
    end
    assign prime = pc != '0;
    // acc: transition accepted this edge; hit: accepted and its direction enabled
    always_comb begin
        acc = '0;
        hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc[i] = !prime && (y[i] != out[i]) && (cnt[i] == CMAX);
            hit[i] = acc[i] && (y[i] ? bus.mode[2*i] : bus.mode[2*i+1]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= PC_INIT;
            rdy  <= 1'b0;
            out  <= '0;
            en   <= '0;
            pend <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            if (prime) pc <= pc - PW'(1);
            rdy  <= rdy | (pc == PW'(1));
            en   <= hit;
            pend <= hit | (pend & ~bus.clr);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= (prime || y[i] == out[i] || acc[i]) ? '0 : cnt[i] + CW'(1);
                if (prime || acc[i]) out[i] <= y[i];
            end
        end
    end
    assign bus.en   = en;
    assign bus.out  = out;
    assign bus.pend = pend;
    assign bus.irq  = |pend;
    assign bus.rdy  = rdy;
endmodule

// File: tb/tb_edge_event_bank.sv
// tb_edge_event_bank: directed self-checking bench for edge_event_bank
module tb_edge_event_bank;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n [W];
    edge_event_bank_if #(.WIDTH(W)) bus ();
    edge_event_bank #(.WIDTH(W), .SYNC_STG(2), .DB_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic count_en(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            for (int i = 0; i < W; i++) n[i] += int'(bus.en[i]);
        end
    endtask
    initial begin
        bus.in   = 4'b1010;
        bus.mode = 8'h55;
        bus.clr  = '0;
        tick();
        tick();
        chk("rst_rdy", 32'(bus.rdy), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_en", 32'(bus.en), 0);
        chk("rst_pend", 32'(bus.pend), 0);
        chk("rst_irq", 32'(bus.irq), 0);
        rst = 1'b0;
        tick();
        chk("prime0_rdy", 32'(bus.rdy), 0);
        tick();
        chk("prime1_rdy", 32'(bus.rdy), 0);
        chk("prime1_en", 32'(bus.en), 0);
        tick();
        chk("prime2_rdy", 32'(bus.rdy), 1);
        chk("prime2_out", 32'(bus.out), 32'hA);
        chk("prime2_pend", 32'(bus.pend), 0);
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk("idle_en", 32'(bus.en), 0);
            chk("idle_pend", 32'(bus.pend), 0);
            chk("idle_out", 32'(bus.out), 32'hA);
        end
        bus.in = 4'b1011;
        for (int k = 10; k <= 14; k++) begin
            tick();
            chk("lat_wait_en", 32'(bus.en), 0);
            chk("lat_wait_out", 32'(bus.out), 32'hA);
        end
        tick();
        chk("lat_en", 32'(bus.en), 1);
        chk("lat_out", 32'(bus.out), 32'hB);
        chk("lat_pend", 32'(bus.pend), 1);
        chk("lat_irq", 32'(bus.irq), 1);
        tick();
        chk("lat_en_once", 32'(bus.en), 0);
        chk("lat_pend_hold", 32'(bus.pend), 1);
        bus.clr = 4'hF;
        tick();
        bus.clr = '0;
        chk("clr_pend", 32'(bus.pend), 0);
        chk("clr_irq", 32'(bus.irq), 0);
        bus.in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("fall_rise_only_en", 32'(bus.en), 0);
        end
        chk("fall_out", 32'(bus.out), 0);
        chk("fall_pend", 32'(bus.pend), 0);
        bus.in = 4'b0010;
        repeat (3) tick();
        bus.in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch_en", 32'(bus.en), 0);
            chk("glitch_out", 32'(bus.out), 0);
        end
        for (int i = 0; i < W; i++) n[i] = 0;
        bus.in = 4'b0010;
        count_en(4);
        bus.in = 4'b0000;
        count_en(12);
        chk("pulse4_count", 32'(n[1]), 1);
        chk("pulse4_pend", 32'(bus.pend), 32'h2);
        chk("pulse4_out", 32'(bus.out), 0);
        bus.clr = 4'hF;
        tick();
        bus.clr = '0;
        bus.mode = 8'hE4;
        for (int i = 0; i < W; i++) n[i] = 0;
        bus.in = 4'b1111;
        count_en(8);
        chk("modes_out_hi", 32'(bus.out), 32'hF);
        bus.in = 4'b0000;
        count_en(12);
        chk("modes_out_lo", 32'(bus.out), 0);
        chk("modes_n0", 32'(n[0]), 0);
        chk("modes_n1", 32'(n[1]), 1);
        chk("modes_n2", 32'(n[2]), 1);
        chk("modes_n3", 32'(n[3]), 2);
        chk("modes_pend", 32'(bus.pend), 32'hE);
        bus.clr = 4'hF;
        tick();
        bus.clr = '0;
        bus.mode = 8'h55;
        bus.in = 4'b0100;
        repeat (5) tick();
        chk("race_pre_en", 32'(bus.en), 0);
        bus.clr = 4'b0100;
        tick();
        chk("race_en", 32'(bus.en), 32'h4);
        chk("race_pend", 32'(bus.pend), 32'h4);
        tick();
        chk("race_clr_pend", 32'(bus.pend), 0);
        chk("race_clr_irq", 32'(bus.irq), 0);
        bus.clr = '0;
        bus.in = 4'b0101;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_en", 32'(bus.en), 0);
        chk("mid_rst_out", 32'(bus.out), 0);
        chk("mid_rst_pend", 32'(bus.pend), 0);
        chk("mid_rst_rdy", 32'(bus.rdy), 0);
        chk("mid_rst_irq", 32'(bus.irq), 0);
        tick();
        tick();
        chk("reprime1_rdy", 32'(bus.rdy), 0);
        tick();
        chk("reprime2_rdy", 32'(bus.rdy), 1);
        chk("reprime2_out", 32'(bus.out), 32'h5);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("reprime_en", 32'(bus.en), 0);
            chk("reprime_pend", 32'(bus.pend), 0);
            chk("reprime_out", 32'(bus.out), 32'h5);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
